// File: rtl/definition.sv
// Shared definitions for the stage datapath: token width, classifier score
// width and the classifier FSM state encoding.
package definition;

    localparam int att_width   = 16;
    localparam int score_width = 2 * att_width;

    typedef enum logic [2:0] {
        CLS_IDLE,
        CLS_ACCUM,
        CLS_POOL,
        CLS_SCORE,
        CLS_DONE
    } cls_state_t;

endpackage

// File: rtl/cls_weight_file.sv
// Runtime-loaded per-class weight/bias registers with one write port and one
// combinational read port; a read in the write cycle returns the old entry.
module cls_weight_file
    import definition::*;
#(
    parameter int N_CLS = 10
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       w_we,
    input  logic                       w_sel,
    input  logic [$clog2(N_CLS)-1:0]   w_addr,
    input  logic [att_width-1:0]       w_data,
    input  logic [$clog2(N_CLS)-1:0]   rd_addr,
    output logic [att_width-1:0]       rd_weight,
    output logic [att_width-1:0]       rd_bias
);

    localparam int CW  = $clog2(N_CLS);
    localparam int CWP = CW + 1;

    logic [att_width-1:0] weight [N_CLS];
    logic [att_width-1:0] bias   [N_CLS];
    logic                 addr_ok;

    // Addresses past the last class are dropped rather than aliased.
    assign addr_ok = ({1'b0, w_addr} < CWP'(N_CLS));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < N_CLS; i++) begin
                weight[i] <= '0;
                bias[i]   <= '0;
            end
        end else if (w_we && addr_ok) begin
            if (w_sel) begin
                bias[w_addr] <= w_data;
            end else begin
                weight[w_addr] <= w_data;
            end
        end
    end

    assign rd_weight = weight[rd_addr];
    assign rd_bias   = bias[rd_addr];

endmodule

// File: rtl/stage_pool_classifier.sv
// Final datapath block: averages N_TOK stage tokens, scores the pooled value
// against each class one per cycle and reports the argmax with a done strobe.
module stage_pool_classifier
    import definition::*;
#(
    parameter int N_TOK = 16,
    parameter int N_CLS = 10
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       en,
    input  logic                       i_valid,
    input  logic [att_width-1:0]       i_token,
    input  logic                       w_we,
    input  logic                       w_sel,
    input  logic [$clog2(N_CLS)-1:0]   w_addr,
    input  logic [att_width-1:0]       w_data,
    output logic                       o_busy,
    output logic                       o_done,
    output logic [$clog2(N_CLS)-1:0]   o_class,
    output logic [score_width-1:0]     o_score
);

    localparam int TW = $clog2(N_TOK);
    localparam int CW = $clog2(N_CLS);
    localparam int AW = att_width + TW;

    cls_state_t             state;
    logic [AW-1:0]          acc;
    logic [TW-1:0]          tok_cnt;
    logic [CW-1:0]          cls_cnt;
    logic [att_width-1:0]   pooled;
    logic [CW-1:0]          best_cls;
    logic [score_width-1:0] best_score;
    logic [att_width-1:0]   rd_weight;
    logic [att_width-1:0]   rd_bias;
    logic [score_width-1:0] score;
    logic                   take_new;
    logic                   last_tok;
    logic                   last_cls;

    cls_weight_file #(
        .N_CLS (N_CLS)
    ) u_weight_file (
        .clk       (clk),
        .rstn      (rstn),
        .w_we      (w_we),
        .w_sel     (w_sel),
        .w_addr    (w_addr),
        .w_data    (w_data),
        .rd_addr   (cls_cnt),
        .rd_weight (rd_weight),
        .rd_bias   (rd_bias)
    );

    // Class 0 always seeds the running best; later classes need a strictly
    // larger score, so ties keep the lowest index.
    assign score    = score_width'(pooled) * score_width'(rd_weight) + score_width'(rd_bias);
    assign take_new = (cls_cnt == '0) || (score > best_score);
    assign last_tok = (tok_cnt == TW'(N_TOK - 1));
    assign last_cls = (cls_cnt == CW'(N_CLS - 1));
    assign o_busy   = (state == CLS_ACCUM) || (state == CLS_POOL) || (state == CLS_SCORE);

    // Dropping en in any busy state abandons the run without touching the
    // result registers; o_done is raised on the edge that enters DONE.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= CLS_IDLE;
            acc        <= '0;
            tok_cnt    <= '0;
            cls_cnt    <= '0;
            pooled     <= '0;
            best_cls   <= '0;
            best_score <= '0;
            o_done     <= 1'b0;
            o_class    <= '0;
            o_score    <= '0;
        end else begin
            o_done <= 1'b0;
            case (state)
                CLS_IDLE: begin
                    if (en) begin
                        state   <= CLS_ACCUM;
                        acc     <= '0;
                        tok_cnt <= '0;
                        cls_cnt <= '0;
                    end
                end
                CLS_ACCUM: begin
                    if (!en) begin
                        state <= CLS_IDLE;
                    end else if (i_valid) begin
                        acc     <= acc + AW'(i_token);
                        tok_cnt <= tok_cnt + TW'(1);
                        if (last_tok) begin
                            state <= CLS_POOL;
                        end
                    end
                end
                CLS_POOL: begin
                    if (!en) begin
                        state <= CLS_IDLE;
                    end else begin
                        pooled <= acc[AW-1:TW];
                        state  <= CLS_SCORE;
                    end
                end
                CLS_SCORE: begin
                    if (!en) begin
                        state <= CLS_IDLE;
                    end else begin
                        if (take_new) begin
                            best_cls   <= cls_cnt;
                            best_score <= score;
                        end
                        if (last_cls) begin
                            state   <= CLS_DONE;
                            o_done  <= 1'b1;
                            o_class <= take_new ? cls_cnt : best_cls;
                            o_score <= take_new ? score : best_score;
                        end else begin
                            cls_cnt <= cls_cnt + CW'(1);
                        end
                    end
                end
                CLS_DONE: begin
                    state <= CLS_IDLE;
                end
                default: begin
                    state <= CLS_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stage_pool_classifier.sv
// Self-checking bench for stage_pool_classifier: directed scenarios with literal
// results plus a randomized phase, all checked each cycle against a reference model.
module tb_stage_pool_classifier;
    import definition::*;

    localparam int N_TOK = 4;
    localparam int N_CLS = 4;
    localparam int CW    = 2;

    logic                   clk     = 1'b0;
    logic                   rstn    = 1'b1;
    logic                   en      = 1'b0;
    logic                   i_valid = 1'b0;
    logic [att_width-1:0]   i_token = '0;
    logic                   w_we    = 1'b0;
    logic                   w_sel   = 1'b0;
    logic [CW-1:0]          w_addr  = '0;
    logic [att_width-1:0]   w_data  = '0;
    logic                   o_busy;
    logic                   o_done;
    logic [CW-1:0]          o_class;
    logic [score_width-1:0] o_score;

    int n_cmp = 0;
    int n_bad = 0;

    stage_pool_classifier #(
        .N_TOK (N_TOK),
        .N_CLS (N_CLS)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .en      (en),
        .i_valid (i_valid),
        .i_token (i_token),
        .w_we    (w_we),
        .w_sel   (w_sel),
        .w_addr  (w_addr),
        .w_data  (w_data),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_class (o_class),
        .o_score (o_score)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a run is a list of accepted tokens, then one pooling
    // step, then one class scored per cycle from the weights current at that time.
    longint unsigned mw [N_CLS];
    longint unsigned mb [N_CLS];
    int              m_mode = 0;
    longint unsigned m_sum = 0;
    int              m_ntok = 0;
    int              m_k = 0;
    longint unsigned m_pooled = 0;
    longint unsigned m_best = 0;
    longint unsigned m_s = 0;
    int              m_best_cls = 0;
    logic            exp_busy = 1'b0;
    logic            exp_done = 1'b0;
    logic [CW-1:0]   exp_class = '0;
    logic [31:0]     exp_score = '0;

    task automatic model_step();
        if (!rstn) begin
            for (int i = 0; i < N_CLS; i++) begin
                mw[i] = 0;
                mb[i] = 0;
            end
            m_mode = 0; m_sum = 0; m_ntok = 0; m_k = 0; m_pooled = 0; m_best = 0; m_best_cls = 0;
            exp_busy = 1'b0; exp_done = 1'b0; exp_class = '0; exp_score = '0;
        end else begin
            exp_done = 1'b0;
            case (m_mode)
                0: if (en) begin m_mode = 1; m_sum = 0; m_ntok = 0; end
                1: begin
                    if (!en) m_mode = 0;
                    else if (i_valid) begin
                        m_sum += i_token;
                        m_ntok++;
                        if (m_ntok == N_TOK) begin m_mode = 2; m_k = -1; end
                    end
                end
                2: begin
                    if (!en) m_mode = 0;
                    else if (m_k < 0) begin
                        m_pooled = (m_sum / N_TOK) % 65536;
                        m_k = 0;
                    end else begin
                        m_s = (m_pooled * mw[m_k] + mb[m_k]) % 64'h1_0000_0000;
                        if (m_k == 0 || m_s > m_best) begin m_best = m_s; m_best_cls = m_k; end
                        if (m_k == N_CLS - 1) begin
                            m_mode = 3;
                            exp_done = 1'b1;
                            exp_class = m_best_cls[CW-1:0];
                            exp_score = m_best[31:0];
                        end else m_k++;
                    end
                end
                default: m_mode = 0;
            endcase
            if (w_we && int'(w_addr) < N_CLS) begin
                if (w_sel) mb[w_addr] = w_data;
                else mw[w_addr] = w_data;
            end
            exp_busy = (m_mode == 1) || (m_mode == 2);
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rstn);
        model_step();
    end

    initial forever begin
        @(posedge clk);
        #1;
        check("busy", o_busy, exp_busy);
        check("done", o_done, exp_done);
        check("class", o_class, exp_class);
        check("score", o_score, exp_score);
    end

    task automatic write_entry(input logic sel, input int addr, input logic [15:0] data);
        @(negedge clk);
        w_we = 1'b1; w_sel = sel; w_addr = addr[CW-1:0]; w_data = data;
        @(negedge clk);
        w_we = 1'b0;
    endtask

    task automatic load_file(input logic [15:0] w0, w1, w2, w3, b0, b1, b2, b3);
        write_entry(1'b0, 0, w0); write_entry(1'b0, 1, w1);
        write_entry(1'b0, 2, w2); write_entry(1'b0, 3, w3);
        write_entry(1'b1, 0, b0); write_entry(1'b1, 1, b1);
        write_entry(1'b1, 2, b2); write_entry(1'b1, 3, b3);
    endtask

    // Raises en with a bogus token in the IDLE cycle, then sends four tokens
    // with 'gap' invalid cycles before each; returns one cycle after the last accept.
    task automatic apply_stimulus(input logic [15:0] t0, t1, t2, t3, input int gap);
        logic [15:0] toks [4];
        toks = '{t0, t1, t2, t3};
        @(negedge clk);
        en = 1'b1; i_valid = 1'b1; i_token = 16'hBEEF;
        for (int i = 0; i < 4; i++) begin
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                i_valid = 1'b0; i_token = 16'h1234;
            end
            @(negedge clk);
            i_valid = 1'b1; i_token = toks[i];
        end
        @(negedge clk);
        i_valid = 1'b0;
    endtask

    // The cycle following the last accepting edge is numbered 1.
    task automatic check_output(input logic [CW-1:0] cls, input logic [31:0] sc, input bit chk_lat);
        int   cyc;
        logic seen;
        cyc  = 1;
        seen = 1'b0;
        while (cyc < 40 && !seen) begin
            @(posedge clk);
            #1;
            cyc++;
            seen = o_done;
        end
        check("done_seen", seen, 1);
        if (chk_lat) check("done_latency", cyc, 6);
        check("result_class", o_class, cls);
        check("result_score", o_score, sc);
    endtask

    initial begin
        int   runs;
        logic seen;

        // Reset held with random inputs
        #1 rstn = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            en = 1'($urandom); i_valid = 1'($urandom); i_token = 16'($urandom);
            w_we = 1'($urandom); w_sel = 1'($urandom); w_addr = CW'($urandom); w_data = 16'($urandom);
        end
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_class", o_class, 0);
        check("rst_score", o_score, 0);
        @(negedge clk);
        en = 1'b0; i_valid = 1'b0; i_token = '0; w_we = 1'b0; rstn = 1'b1;
        repeat (4) @(posedge clk);
        #1 check("idle_after_reset_busy", o_busy, 0);

        $display("[TB] basic inference");
        load_file(1, 2, 3, 4, 0, 0, 0, 0);
        apply_stimulus(4, 8, 12, 16, 0);
        check_output(3, 40, 1);
        @(posedge clk); #1 check("b2b_idle_gap", o_busy, 0);
        @(posedge clk); #1 check("b2b_restart", o_busy, 1);
        @(negedge clk); en = 1'b0;

        $display("[TB] tie and bias");
        load_file(2, 2, 1, 1, 5, 5, 0, 26);
        apply_stimulus(10, 10, 10, 10, 0);
        check_output(3, 36, 0);
        @(negedge clk); en = 1'b0;
        write_entry(1'b1, 3, 0);
        apply_stimulus(10, 10, 10, 10, 0);
        check_output(0, 25, 0);
        @(negedge clk); en = 1'b0;

        $display("[TB] write collision");
        apply_stimulus(10, 10, 10, 10, 0);
        repeat (3) @(negedge clk);
        w_we = 1'b1; w_sel = 1'b0; w_addr = 2; w_data = 9;
        @(negedge clk);
        w_we = 1'b0;
        check_output(0, 25, 0);
        @(negedge clk); en = 1'b0;
        apply_stimulus(10, 10, 10, 10, 0);
        check_output(2, 90, 0);
        @(negedge clk); en = 1'b0;

        $display("[TB] gapped valid and overflow");
        load_file(1, 0, 0, 0, 0, 0, 0, 0);
        apply_stimulus(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 2);
        check_output(0, 32'h0000_FFFF, 1);
        @(negedge clk); en = 1'b0;

        $display("[TB] abort");
        @(negedge clk); en = 1'b1; i_valid = 1'b0;
        @(negedge clk); i_valid = 1'b1; i_token = 16'd7;
        @(negedge clk); i_token = 16'd9;
        @(negedge clk); en = 1'b0; i_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            seen = seen | o_done;
        end
        check("abort_no_done", seen, 0);
        check("abort_hold_class", o_class, 0);
        check("abort_hold_score", o_score, 32'h0000_FFFF);
        check("abort_idle", o_busy, 0);
        apply_stimulus(100, 200, 300, 400, 1);
        check_output(0, 250, 1);
        @(negedge clk); en = 1'b0;

        $display("[TB] reset mid-run");
        @(negedge clk); en = 1'b1;
        @(negedge clk); i_valid = 1'b1; i_token = 16'd55;
        @(negedge clk); i_valid = 1'b0;
        #3 rstn = 1'b0;
        #1;
        check("midrst_busy", o_busy, 0);
        check("midrst_class", o_class, 0);
        check("midrst_score", o_score, 0);
        @(negedge clk); en = 1'b0; rstn = 1'b1;

        $display("[TB] randomized traffic");
        runs = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (o_done) runs++;
            en      = ($urandom_range(0, 63) != 0);
            i_valid = 1'($urandom);
            i_token = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 20));
            w_we    = ($urandom_range(0, 7) == 0);
            w_sel   = 1'($urandom);
            w_addr  = CW'($urandom);
            w_data  = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 3));
        end
        check("rand_runs_seen", (runs > 0), 1);
        @(negedge clk);
        en = 1'b0; w_we = 1'b0; i_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/stage_pool_classifier.md
# stage_pool_classifier

Downstream consumer of the two-head attention/MLP stage. It collects a fixed number of residual-stage output tokens, average-pools them, and scores the pooled value against a small runtime-loaded weight/bias file, one class per cycle. It reports the argmax class and its score with a one-cycle done strobe. It is the final block of the accelerator datapath.

## Interface
- `N_TOK`, 16: tokens pooled per inference; power of two, ≥2.
- `N_CLS`, 10: number of classes; ≥2.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `en`  in  1  run enable, level-sensitive; low aborts any operation.
- `i_valid`  in  1  token qualifier; driven from the stage's `end_s`.
- `i_token`  in  `att_width`  token value; driven from the stage's `o_stage`.
- `w_we`  in  1  weight-file write enable.
- `w_sel`  in  1  write target: 0 selects weight, 1 selects bias.
- `w_addr`  in  `$clog2(N_CLS)`  class index for the write.
- `w_data`  in  `att_width`  write data.
- `o_busy`  out  1  high in every state except IDLE and DONE.
- `o_done`  out  1  one-cycle result strobe.
- `o_class`  out  `$clog2(N_CLS)`  argmax class index.
- `o_score`  out  `2*att_width`  score of `o_class`.

## Operation
- All arithmetic is unsigned and wraps modulo the stated width.
- **Weight file:** `N_CLS` weights and `N_CLS` biases, each `att_width` bits; all reset to 0.
  - A write happens on any cycle with `w_we=1`, in any state.
  - `w_addr ≥ N_CLS` is ignored.
  - When the SCORE state reads an entry in the same cycle it is written, SCORE uses the old value.
- **FSM states:** IDLE, ACCUM, POOL, SCORE, DONE.
  - IDLE: when `en=1`, go to ACCUM and clear the accumulator, token counter and class counter.
  - ACCUM: each cycle with `i_valid=1`, `acc += i_token` and `tok_cnt++`. When the `N_TOK`-th token is accepted, go to POOL. Cycles with `i_valid=0` are ignored.
  - POOL: `pooled = acc >> log2(N_TOK)`. The accumulator is `att_width+log2(N_TOK)` bits wide, so it never overflows. `pooled` is truncated to `att_width`.
  - SCORE: one class per cycle, `c = 0..N_CLS-1`. `s = pooled*W[c] + B[c]`, kept to `2*att_width` bits.
    - Class 0 always loads `best`.
    - Each later class replaces `best` only if its score is strictly greater, so ties keep the lowest index.
    - After class `N_CLS-1`, go to DONE.
  - DONE: `o_done=1` for one cycle, and `o_class`/`o_score` are loaded from `best`. Then go to IDLE, which restarts at once if `en` is still high.
- **Abort:** `en=0` in ACCUM, POOL or SCORE returns the FSM to IDLE next cycle. There is no done strobe and `o_class`/`o_score` are not updated.
- **Output hold:** `o_class`/`o_score` hold their value until the next DONE.

## Timing
- **Reset values:** all outputs 0, state IDLE, counters 0, weight file 0.
- **Start:** `en` sampled high in IDLE gives ACCUM on the next cycle. Tokens are accepted from that cycle onward; `i_valid` during the IDLE cycle is ignored.
- **Latency:** the last token is accepted at edge t.
  - POOL at t+1.
  - SCORE at t+2 through t+1+`N_CLS`.
  - DONE at t+2+`N_CLS`, with `o_done` high in that cycle and outputs valid from that cycle.
- **Reset mid-operation:** reset asserted at any point returns everything to reset values immediately, with no clock needed.
- **Throughput:** back-to-back inferences with `en` held high have exactly 1 IDLE cycle between DONE and ACCUM.

## Structure
- Shared package `definition`, used alongside the existing `att_width`:
  - typedef of the FSM state enum `cls_state_t`.
  - localparam for the score width `2*att_width`.
- Sub-module `cls_weight_file`: the `N_CLS`-entry weight/bias register file, with the write port and one combinational read port indexed by the class counter.
- Top level: FSM, accumulator, pooling, MAC, argmax and output registers.

## Test plan
All scenarios use `att_width=16`, `N_TOK=4`, `N_CLS=4`.
- **Reset:** hold `rstn=0` with random inputs. All outputs stay 0. After release with `en=0`, the block stays IDLE and `o_busy=0`.
- **Basic inference:**
  - Load W = {1,2,3,4}, B = {0,0,0,0}.
  - Send tokens 4, 8, 12, 16 with `i_valid` continuous.
  - Expect pooled = 10, `o_class=3`, `o_score=40`.
  - `o_done` appears 6 cycles after the last token edge.
- **Tie and bias:**
  - W = {2,2,1,1}, B = {5,5,0,26}, tokens all 10.
  - Scores are {25,25,10,36}, giving `o_class=3`, `o_score=36`.
  - Then set B[3]=0: the result becomes `o_class=0`, `o_score=25`.
- **Gapped valid and overflow:**
  - Tokens 0xFFFF ×4 with `i_valid` gaps between them, W[0]=1, all other weights 0.
  - Expect pooled = 0xFFFF and `o_score=0xFFFF`.
  - Gap cycles must not be counted as tokens.
- **Abort:**
  - Drop `en` after 2 tokens. No `o_done`, and the previous `o_class`/`o_score` are unchanged.
  - Re-raise `en`: a full 4-token run completes normally.
- **Write collision:** write W[2] in the same cycle class 2 is scored. The old value is used in that run and the new value in the next run.
